// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
package arb_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Priority starts at requester 0 out of reset.
  localparam logic [NREQ-1:0] PTR_RESET = 4'b0001;

  // One step of the priority ring: requester k hands priority to k+1 (mod 4).
  function automatic logic [NREQ-1:0] rotl1(input logic [NREQ-1:0] v);
    return {v[NREQ-2:0], v[NREQ-1]};
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: rotate the request vector so the pointer
// position sits at bit 0, take the lowest set bit, then rotate back.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] ptr,
  output logic [NREQ-1:0] pick,
  output logic            any
);

  logic [1:0]        idx;
  logic [2*NREQ-1:0] rot_dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   first;
  logic [2*NREQ-1:0] back_dbl;

  // Rotate, priority-encode, rotate back.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ptr[i]) idx = 2'(i);
    end

    rot_dbl = {req, req} >> idx;
    rot     = rot_dbl[NREQ-1:0];

    first = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rot[i] && (first == '0)) first[i] = 1'b1;
    end

    back_dbl = {first, first} << idx;
    pick     = back_dbl[2*NREQ-1:NREQ];
    any      = |req;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with one-hot registered grant, release on
// done or request drop, and an optional hold timeout.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            timeout
);

  localparam bit            HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

  state_t          state, state_next;
  logic [NREQ-1:0] ptr, ptr_next;
  logic [CW-1:0]   hold_cnt, cnt_next;
  logic [NREQ-1:0] grant_next;
  logic            timeout_next;

  logic            rel;
  logic            expire;
  logic            end_grant;
  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] pick_ptr;
  logic [NREQ-1:0] pick;
  logic            any;

  // Single picker serves both the idle search and the handover search.
  rr_pick4 u_pick (
    .req  (pick_req),
    .ptr  (pick_ptr),
    .pick (pick),
    .any  (any)
  );

  // State register plus all registered outputs; reset wins over everything.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= PTR_RESET;
      hold_cnt <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      hold_cnt <= cnt_next;
      grant    <= grant_next;
      busy     <= |grant_next;
      timeout  <= timeout_next;
    end
  end

  // Handover decision: release, expiry, and what the picker searches.
  // After a release the owner is masked out; after a timeout it stays
  // eligible but sits last in rotation, so a sole requester is re-granted.
  always_comb begin
    rel       = done | ~|(req & grant);
    expire    = 1'b0;
    end_grant = 1'b0;
    pick_req  = req;
    pick_ptr  = ptr;
    if (state == OWN) begin
      expire    = HOLD_EN && (hold_cnt == HOLD_LAST) && !rel;
      end_grant = rel | expire;
      pick_ptr  = rotl1(grant);
      if (rel) pick_req = req & ~grant;
    end
  end

  // Next-state logic for IDLE / OWN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = any ? OWN : IDLE;
      OWN:     if (end_grant) state_next = any ? OWN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of grant, pointer, hold counter and timeout pulse.
  always_comb begin
    grant_next   = grant;
    ptr_next     = ptr;
    cnt_next     = hold_cnt;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        grant_next = pick;
        cnt_next   = '0;
      end
      OWN: begin
        if (end_grant) begin
          grant_next   = pick;
          ptr_next     = rotl1(grant);
          cnt_next     = '0;
          timeout_next = expire;
        end else begin
          cnt_next = hold_cnt + CW'(1);
        end
      end
      default: grant_next = '0;
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4 with a behavioural round-robin model.
module tb_rr_arbiter4;

  localparam int M = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter4 #(.MAX_HOLD(M)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = none), priority index, cycles held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  always @(posedge clk) begin
    bit rel_m, exp_m, found;
    int k, idx;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to  = 1'b0;
      found = 1'b0;
      for (int j = 0; j < 4; j++) begin
        idx = (m_ptr + j) % 4;
        if (!found && req[idx]) begin
          found = 1'b1; m_owner = idx; m_held = 1;
        end
      end
    end else begin
      rel_m = done || !req[m_owner];
      exp_m = (M != 0) && (m_held == M) && !rel_m;
      if (rel_m || exp_m) begin
        k       = m_owner;
        m_ptr   = (k + 1) % 4;
        m_owner = -1;
        found   = 1'b0;
        for (int j = 0; j < 4; j++) begin
          idx = (m_ptr + j) % 4;
          if (!found && req[idx] && !(rel_m && idx == k)) begin
            found = 1'b1; m_owner = idx; m_held = 1;
          end
        end
        m_to = exp_m;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] eg;
    eg = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    check("model_grant",   32'(grant),   eg);
    check("model_busy",    32'(busy),    32'(m_owner >= 0));
    check("model_timeout", 32'(timeout), 32'(m_to));
    check("model_ptr",     32'(dut.ptr), 32'd1 << m_ptr);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    reset = 1'b1; req = 4'b0000; done = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] seq[$];
    logic [3:0] g[6];
    logic       t[6];
    int         n_to;
    bit         cont;

    reset = 1'b1; req = 4'b0000; done = 1'b0;
    tick();
    check("rst_grant",   32'(grant),   32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_ptr",     32'(dut.ptr), 32'h1);
    reset = 1'b0;

    // Single request, then release with done.
    req = 4'b0100;
    tick();
    check("single_grant", 32'(grant), 32'h4);
    done = 1'b1; req = 4'b0000;
    tick();
    done = 1'b0;
    check("single_rel_grant", 32'(grant),   32'h0);
    check("single_rel_busy",  32'(busy),    32'h0);
    check("single_rel_ptr",   32'(dut.ptr), 32'h8);

    // Full contention, done every third cycle.
    reset_dut();
    req = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (seq.size() == 0 || seq[$] != grant) seq.push_back(grant);
      done = (i % 3 == 2);
    end
    done = 1'b0;
    check("rot_count", 32'(seq.size()), 32'd5);
    if (seq.size() == 5) begin
      check("rot_0", 32'(seq[0]), 32'h1);
      check("rot_1", 32'(seq[1]), 32'h2);
      check("rot_2", 32'(seq[2]), 32'h4);
      check("rot_3", 32'(seq[3]), 32'h8);
      check("rot_4", 32'(seq[4]), 32'h1);
    end

    // Timeout with a waiting second requester.
    reset_dut();
    req = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      tick();
      g[i] = grant;
      t[i] = timeout;
    end
    check("to_hold_last",  32'(g[3]), 32'h1);
    check("to_pre_pulse",  32'(t[3]), 32'h0);
    check("to_handover",   32'(g[4]), 32'h2);
    check("to_pulse",      32'(t[4]), 32'h1);
    check("to_pulse_once", 32'(t[5]), 32'h0);

    // Sole requester: continuous grant, periodic timeout.
    reset_dut();
    req  = 4'b0001;
    n_to = 0;
    cont = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (timeout) n_to++;
      if (grant != 4'b0001) cont = 1'b0;
    end
    check("sole_continuous", 32'(cont), 32'h1);
    check("sole_to_count",   32'(n_to), 32'd2);

    // Request drop acts as a release.
    reset_dut();
    req = 4'b0100;
    tick();
    check("drop_grant", 32'(grant), 32'h4);
    req = 4'b0001;
    tick();
    check("drop_handover", 32'(grant),   32'h1);
    check("drop_no_to",    32'(timeout), 32'h0);

    // Reset in the middle of a grant.
    reset_dut();
    req = 4'b1000;
    tick();
    check("mid_grant", 32'(grant), 32'h8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_grant", 32'(grant),   32'h0);
    check("mid_rst_ptr",   32'(dut.ptr), 32'h1);
    req = 4'b1001;
    tick();
    check("mid_regrant", 32'(grant), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-way round-robin arbiter that shares one resource among four requesters and issues a one-hot grant. Rotation state is a one-hot priority pointer that advances like a 4-stage ring counter. A grant is held until the owner releases it or a hold-timeout expires. The arbiter sits in front of a shared datapath unit and drives its per-requester select/enable lines directly from `grant`.

## Interface
Parameters:
- `MAX_HOLD`, default 15: maximum consecutive cycles one grant may be held. 0 disables the timeout.
- `CW`, default `$clog2(MAX_HOLD+1)`: width of the hold counter. Derived; not overridden.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in 4: request lines; `req[i]` is level-held by requester i.
- `done` in 1: release strobe from the current owner; ignored when no grant is active.
- `grant` out 4: registered one-hot grant, or 0.
- `busy` out 1: registered; equals `|grant`.
- `timeout` out 1: registered one-cycle pulse when a grant is force-revoked.

## Operation
- State machine with two states:
  - IDLE: no grant active.
  - OWN: exactly one `grant` bit is set.
- Priority pointer `ptr`: 4-bit one-hot register.
  - Search order starts at the `ptr` position and wraps 0→1→2→3→0.
  - After a grant to requester k ends, `ptr` becomes one-hot at (k+1) mod 4.
- Release condition, evaluated in OWN: `rel = done | ~req[k]`, where k is the granted index. Dropping `req` is treated the same as `done`.
- Hold counter: counts cycles spent in OWN; cleared on every new grant.
- Timeout: when `MAX_HOLD != 0`, the counter equals `MAX_HOLD-1`, and `rel=0`, the grant is revoked.
  - `timeout` pulses in the same cycle the grant drops.
  - `ptr` advances exactly as for a normal release.
- Transitions:
  - IDLE with `|req=0`: stay in IDLE.
  - IDLE with `|req=1`: go to OWN and grant the first set `req` bit in search order from `ptr`.
  - OWN with no release and no timeout: stay; the grant is unchanged.
  - OWN with a release or timeout: pick the next requester from the rotated pointer, excluding k. If one exists, move directly to its grant with no idle bubble. If none exists, go to IDLE with `grant=0`.
- Ownership is never pre-empted by a higher-priority request arriving.
- If k still requests after a timeout, it is re-granted only after the other requesters have had their turn in rotation. When k is the sole requester, the re-grant comes on the next cycle with a zero bubble, and `timeout` still pulses.
- Reset values: state IDLE, `grant=0000`, `busy=0`, `timeout=0`, `ptr=0001`, hold counter 0.
- Reset has priority over every other event, including mid-grant. The grant drops on the edge where `reset` is sampled high.

## Timing
- Request-to-grant latency: `req` sampled high at edge n while in IDLE gives `grant` high after edge n.
- Release-to-handover latency: `rel` sampled at edge n gives the new grant (or 0) valid after edge n, with zero idle cycles between owners.
- `done` and `req` changes in the same cycle as a new grant are not seen until the following edge.
- With MAX_HOLD=M, one grant lasts at most M cycles. `timeout` is high during the first cycle after the grant drops.
- Simultaneous `done` and timeout in the same cycle: treated as a normal release, and `timeout` stays 0.
- `grant` is never multi-hot and never X after reset. A `grant` bit is never set for a requester whose `req` is low at the decision edge.

## Structure
- Shared package `arb_pkg`:
  - `NREQ=4`
  - state typedef {IDLE, OWN}
  - one-hot constant `PTR_RESET=4'b0001`
- Sub-module `rr_pick4` (combinational), inputs and outputs:
  - input `req[3:0]` plus one-hot `ptr`
  - outputs one-hot `pick` and `any`, implemented as a rotate, priority encode, rotate back
  - Instantiated once. Handover masks out k at the `req` input.
- Top module holds the state register, `ptr`, the hold counter, and the output registers.

## Test plan
- Reset then single request: `req=0100` → `grant=0100` one cycle later. `done` pulse → `grant=0000`, `busy=0`, `ptr=1000`.
- Full contention: `req=1111` held, `done` pulsed every 3rd cycle → grants cycle 0001, 0010, 0100, 1000, 0001 with zero bubbles.
- Timeout: MAX_HOLD=4, `req=0011`, no `done` → `grant=0001` for exactly 4 cycles, then `grant=0010` with `timeout=1` for one cycle.
- Sole-requester timeout: MAX_HOLD=4, `req=0001` only → `grant` is continuous, and `timeout` pulses after every 4 cycles of grant.
- Request drop: grant=0100, then `req[2]` deasserted with no `done` → handover on the next edge as a normal release, `timeout=0`.
- Reset mid-grant: grant=1000 with `reset` high for one cycle → `grant=0000`, `ptr=0001`. `req=1001` then → `grant=0001`.
